// File: rtl/priority_decoder8_assembler.sv
// Rebuilds an 8-bit request vector from a descending stream of priority codes,
// presenting it with a valid/ready handshake, a set-bit count and an ordering-error flag.
module priority_decoder8_assembler #(
    parameter int WIDTH  = 8,
    parameter int CODE_W = 3
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [CODE_W-1:0]            code_in,
    input  logic                         code_empty,
    input  logic                         code_last,
    input  logic                         code_valid,
    output logic                         code_ready,
    output logic [WIDTH-1:0]             vec_out,
    output logic [$clog2(WIDTH+1)-1:0]   vec_cnt,
    output logic                         vec_err,
    output logic                         vec_valid,
    input  logic                         vec_ready
);

    localparam int CNT_W = $clog2(WIDTH+1);

    typedef enum logic {COLLECT, HOLD} state_t;

    state_t              state_q, state_d;
    logic [WIDTH-1:0]    acc_q, acc_d, acc_upd;
    logic [CNT_W-1:0]    cnt_q, cnt_d, cnt_upd;
    logic                err_q, err_d, err_upd;
    logic                first_q, first_d, first_upd;
    logic [CODE_W-1:0]   prev_q, prev_d, prev_upd;
    logic [WIDTH-1:0]    vec_out_q, vec_out_d;
    logic [CNT_W-1:0]    vec_cnt_q, vec_cnt_d;
    logic                vec_err_q, vec_err_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= COLLECT;
            acc_q     <= '0;
            cnt_q     <= '0;
            err_q     <= 1'b0;
            first_q   <= 1'b1;
            prev_q    <= '0;
            vec_out_q <= '0;
            vec_cnt_q <= '0;
            vec_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            acc_q     <= acc_d;
            cnt_q     <= cnt_d;
            err_q     <= err_d;
            first_q   <= first_d;
            prev_q    <= prev_d;
            vec_out_q <= vec_out_d;
            vec_cnt_q <= vec_cnt_d;
            vec_err_q <= vec_err_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        err_d     = err_q;
        first_d   = first_q;
        prev_d    = prev_q;
        vec_out_d = vec_out_q;
        vec_cnt_d = vec_cnt_q;
        vec_err_d = vec_err_q;
        acc_upd   = acc_q;
        cnt_upd   = cnt_q;
        err_upd   = err_q;
        first_upd = first_q;
        prev_upd  = prev_q;

        case (state_q)
            COLLECT: begin
                if (code_valid) begin
                    if (!code_empty) begin
                        acc_upd = acc_q | (WIDTH'(1) << code_in);
                        if (!acc_q[code_in]) begin
                            cnt_upd = cnt_q + CNT_W'(1);
                        end
                        // Codes must be strictly descending; equal covers duplicates
                        if (!first_q && (code_in >= prev_q)) begin
                            err_upd = 1'b1;
                        end
                        prev_upd  = code_in;
                        first_upd = 1'b0;
                    end else if (!first_q) begin
                        err_upd = 1'b1;
                    end

                    if (code_last) begin
                        vec_out_d = acc_upd;
                        vec_cnt_d = cnt_upd;
                        vec_err_d = err_upd;
                        acc_d     = '0;
                        cnt_d     = '0;
                        err_d     = 1'b0;
                        first_d   = 1'b1;
                        prev_d    = '0;
                        state_d   = HOLD;
                    end else begin
                        acc_d   = acc_upd;
                        cnt_d   = cnt_upd;
                        err_d   = err_upd;
                        first_d = first_upd;
                        prev_d  = prev_upd;
                    end
                end
            end
            HOLD: begin
                if (vec_ready) begin
                    state_d = COLLECT;
                end
            end
            default: state_d = COLLECT;
        endcase
    end

    assign code_ready = (state_q == COLLECT);
    assign vec_valid  = (state_q == HOLD);
    assign vec_out    = vec_out_q;
    assign vec_cnt    = vec_cnt_q;
    assign vec_err    = vec_err_q;

endmodule

// File: tb/tb_priority_decoder8_assembler.sv
// Bench for priority_decoder8_assembler: directed frames followed by random frames
// checked against a frame-level reference model.
module tb_priority_decoder8_assembler;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [2:0] code_in;
    logic       code_empty;
    logic       code_last;
    logic       code_valid;
    logic       code_ready;
    logic [7:0] vec_out;
    logic [3:0] vec_cnt;
    logic       vec_err;
    logic       vec_valid;
    logic       vec_ready;

    int total  = 0;
    int passes = 0;
    int fails  = 0;
    int frame_no = 0;

    int fb_code[$];
    bit fb_empty[$];

    always #5 clk = ~clk;

    priority_decoder8_assembler dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .code_in    (code_in),
        .code_empty (code_empty),
        .code_last  (code_last),
        .code_valid (code_valid),
        .code_ready (code_ready),
        .vec_out    (vec_out),
        .vec_cnt    (vec_cnt),
        .vec_err    (vec_err),
        .vec_valid  (vec_valid),
        .vec_ready  (vec_ready)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passes++;
        else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Frame-level model: OR of the coded bits, popcount, and an error if the
    // non-empty codes are not strictly descending or an empty beat follows a code.
    task automatic model(output logic [7:0] v, output logic [3:0] c, output logic e);
        int nz[$];
        int first_nz;
        v = 8'h00;
        e = 1'b0;
        first_nz = fb_code.size();
        for (int i = 0; i < fb_code.size(); i++) begin
            if (!fb_empty[i]) begin
                nz.push_back(fb_code[i]);
                v[fb_code[i]] = 1'b1;
                if (i < first_nz) first_nz = i;
            end
        end
        for (int i = 1; i < nz.size(); i++)
            if (!(nz[i] < nz[i-1])) e = 1'b1;
        for (int i = first_nz + 1; i < fb_empty.size(); i++)
            if (fb_empty[i]) e = 1'b1;
        c = 4'($countones(v));
    endtask

    task automatic send_beat(input int code, input bit empty, input bit last);
        int k;
        code_in    = 3'(code);
        code_empty = empty;
        code_last  = last;
        code_valid = 1'b1;
        k = 0;
        while (!code_ready && k < 20) begin
            @(posedge clk); #1;
            k++;
        end
        if (!code_ready) chk("ready_timeout", 32'(code_ready), 32'd1);
        @(posedge clk); #1;
        code_valid = 1'b0;
    endtask

    task automatic run_frame(input int hold, input bit junk, input int dvec, input int dcnt, input int derr);
        logic [7:0] ev;
        logic [3:0] ec;
        logic       ee;
        model(ev, ec, ee);
        for (int i = 0; i < fb_code.size(); i++) begin
            send_beat(fb_code[i], fb_empty[i], i == fb_code.size() - 1);
            if (i != fb_code.size() - 1 && $urandom_range(0, 3) == 0) begin
                repeat ($urandom_range(1, 3)) @(posedge clk);
                #1;
            end
        end
        chk("vec_valid_latency", 32'(vec_valid), 32'd1);
        chk("vec_out", 32'(vec_out), 32'(ev));
        chk("vec_cnt", 32'(vec_cnt), 32'(ec));
        chk("vec_err", 32'(vec_err), 32'(ee));
        chk("ready_in_hold", 32'(code_ready), 32'd0);
        if (dvec >= 0) begin
            chk("dir_vec", 32'(vec_out), 32'(dvec));
            chk("dir_cnt", 32'(vec_cnt), 32'(dcnt));
            chk("dir_err", 32'(vec_err), 32'(derr));
        end
        $display("frame %0d: beats=%0d vec=%b cnt=%0d err=%0d", frame_no, fb_code.size(), vec_out, vec_cnt, vec_err);
        frame_no++;
        if (junk) begin
            code_in    = 3'($urandom_range(0, 7));
            code_empty = 1'b0;
            code_last  = 1'b1;
            code_valid = 1'b1;
        end
        for (int h = 0; h < hold; h++) begin
            @(posedge clk); #1;
            chk("hold_vec_stable", 32'(vec_out), 32'(ev));
            chk("hold_valid", 32'(vec_valid), 32'd1);
            chk("hold_ready_low", 32'(code_ready), 32'd0);
        end
        code_valid = 1'b0;
        vec_ready  = 1'b1;
        @(posedge clk); #1;
        vec_ready  = 1'b0;
        chk("release_valid", 32'(vec_valid), 32'd0);
        chk("release_ready", 32'(code_ready), 32'd1);
    endtask

    task automatic clr();
        fb_code.delete();
        fb_empty.delete();
    endtask

    task automatic push(input int code, input bit empty);
        fb_code.push_back(code);
        fb_empty.push_back(empty);
    endtask

    initial begin
        rst_n      = 1'b0;
        code_in    = 3'd0;
        code_empty = 1'b0;
        code_last  = 1'b0;
        code_valid = 1'b0;
        vec_ready  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_vec_out", 32'(vec_out), 32'd0);
        chk("rst_vec_cnt", 32'(vec_cnt), 32'd0);
        chk("rst_vec_err", 32'(vec_err), 32'd0);
        chk("rst_vec_valid", 32'(vec_valid), 32'd0);
        chk("rst_code_ready", 32'(code_ready), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;

        clr(); push(7, 0); push(6, 0); push(0, 0);
        run_frame(0, 0, 8'b1100_0001, 3, 0);
        clr(); push(4, 0);
        run_frame(1, 0, 8'b0001_0000, 1, 0);
        clr(); push(0, 1);
        run_frame(0, 0, 8'b0000_0000, 0, 0);
        clr(); push(3, 0); push(5, 0);
        run_frame(0, 0, 8'b0010_1000, 2, 1);
        clr(); push(6, 0); push(6, 0);
        run_frame(0, 0, 8'b0100_0000, 1, 1);
        clr(); push(7, 0);
        run_frame(3, 1, 8'b1000_0000, 1, 0);
        clr(); push(2, 0);
        run_frame(0, 0, 8'b0000_0100, 1, 0);

        // Reset in the middle of a partial frame
        send_beat(7, 0, 0);
        send_beat(6, 0, 0);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_vec_out", 32'(vec_out), 32'd0);
        chk("midrst_vec_cnt", 32'(vec_cnt), 32'd0);
        chk("midrst_vec_valid", 32'(vec_valid), 32'd0);
        chk("midrst_code_ready", 32'(code_ready), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        clr(); push(1, 0);
        run_frame(0, 0, 8'b0000_0010, 1, 0);

        for (int f = 0; f < 60; f++) begin
            clr();
            if ($urandom_range(0, 1) == 0) begin
                logic [7:0] m;
                m = 8'($urandom);
                if (m == 8'h00) push(0, 1);
                for (int b = 7; b >= 0; b--)
                    if (m[b]) push(b, 0);
            end else begin
                int n;
                n = $urandom_range(1, 10);
                for (int i = 0; i < n; i++)
                    push($urandom_range(0, 7), $urandom_range(0, 5) == 0);
            end
            run_frame($urandom_range(0, 3), $urandom_range(0, 1), -1, 0, 0);
        end

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end

endmodule
